// File: rtl/frame_former_manager.sv
// Transmit end of the frame-former path: drains the word buffer into fixed-length AXI-Stream frames,
// zero-padding a starved frame. Define FRAME_HEADER_EN to prefix each frame with one header beat.
module frame_former_manager #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned FRAME_WORDS    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    buf_empty,
  input  logic [DATA_WIDTH-1:0]   buf_data,
  output logic                    buf_pop,
  output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
  output logic                    M_AXIS_tvalid,
  output logic                    M_AXIS_tlast,
  input  logic                    M_AXIS_tready,
  output logic [15:0]             frame_count,
  output logic                    busy
);

  localparam int unsigned KEEP_W = DATA_WIDTH / 8;
  localparam int unsigned BEAT_W = $clog2(FRAME_WORDS + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
`ifdef FRAME_HEADER_EN
  localparam int unsigned LAST_IDX = FRAME_WORDS;
`else
  localparam int unsigned LAST_IDX = FRAME_WORDS - 1;
`endif

`ifdef FRAME_HEADER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, PAD = 2'd2, HDR = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, PAD = 2'd2} state_e;
`endif

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [TO_W-1:0]         to_q, to_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [15:0]             frame_count_q, frame_count_d;

  logic                    slot_free;
  logic                    pop_state;
  logic                    hs_last;
  logic                    at_last;
`ifdef FRAME_HEADER_EN
  logic [63:0]             hdr_word;
`endif

  // Next-state, output-register load and pop decision
  always_comb begin
    slot_free     = !tvalid_q | M_AXIS_tready;
    hs_last       = tvalid_q & M_AXIS_tready & tlast_q;
    at_last       = (beat_q == BEAT_W'(LAST_IDX));
`ifdef FRAME_HEADER_EN
    pop_state     = (state_q == STREAM);
    hdr_word      = {16'hE7A0, frame_count_q, 16'(FRAME_WORDS), 16'h0000};
`else
    pop_state     = (state_q == IDLE) || (state_q == STREAM);
`endif
    buf_pop       = slot_free & !buf_empty & pop_state & !ARESET;

    state_d       = state_q;
    beat_d        = beat_q;
    to_d          = to_q;
    tvalid_d      = tvalid_q & !M_AXIS_tready;
    tlast_d       = slot_free ? 1'b0 : tlast_q;
    tdata_d       = tdata_q;
    frame_count_d = frame_count_q + 16'(hs_last);

    case (state_q)
      IDLE: begin
        beat_d = '0;
        to_d   = '0;
`ifdef FRAME_HEADER_EN
        if (slot_free && !buf_empty) begin
          state_d = HDR;
        end
`else
        if (buf_pop) begin
          tvalid_d = 1'b1;
          tdata_d  = buf_data;
          tlast_d  = 1'b0;
          beat_d   = BEAT_W'(1);
          state_d  = STREAM;
        end
`endif
      end
`ifdef FRAME_HEADER_EN
      HDR: begin
        if (slot_free) begin
          tvalid_d = 1'b1;
          tdata_d  = DATA_WIDTH'(hdr_word);
          tlast_d  = 1'b0;
          beat_d   = BEAT_W'(1);
          state_d  = STREAM;
        end
      end
`endif
      STREAM: begin
        if (buf_pop) begin
          tvalid_d = 1'b1;
          tdata_d  = buf_data;
          to_d     = '0;
          if (at_last) begin
            tlast_d = 1'b1;
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            tlast_d = 1'b0;
            beat_d  = beat_q + BEAT_W'(1);
          end
        end else if (slot_free && buf_empty) begin
          // Only starvation with a free output slot counts toward the timeout
          if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            to_d    = '0;
            state_d = PAD;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
      end
      PAD: begin
        to_d = '0;
        if (slot_free) begin
          tvalid_d = 1'b1;
          tdata_d  = '0;
          if (at_last) begin
            tlast_d = 1'b1;
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            tlast_d = 1'b0;
            beat_d  = beat_q + BEAT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      to_q          <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      to_q          <= to_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tdata_q       <= tdata_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign M_AXIS_tdata  = tdata_q;
  assign M_AXIS_tkeep  = {KEEP_W{1'b1}};
  assign M_AXIS_tvalid = tvalid_q;
  assign M_AXIS_tlast  = tlast_q;
  assign frame_count   = frame_count_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_frame_former_manager.sv
// Bench for frame_former_manager: a queue-based buffer feeds the DUT and a frame-level model
// predicts every accepted beat; honours FRAME_HEADER_EN when defined.
module tb_frame_former_manager;

  localparam int unsigned DW = 64;
  localparam int unsigned FW = 8;
  localparam int unsigned TO = 16;
`ifdef FRAME_HEADER_EN
  localparam int FLEN = FW + 1;
`else
  localparam int FLEN = FW;
`endif

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } beat_t;

  logic            clk;
  logic            ARESET;
  logic            buf_empty;
  logic [DW-1:0]   buf_data;
  logic            buf_pop;
  logic [DW-1:0]   M_AXIS_tdata;
  logic [DW/8-1:0] M_AXIS_tkeep;
  logic            M_AXIS_tvalid;
  logic            M_AXIS_tlast;
  logic            M_AXIS_tready;
  logic [15:0]     frame_count;
  logic            busy;

  frame_former_manager #(
    .DATA_WIDTH    (DW),
    .FRAME_WORDS   (FW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK         (clk),
    .ARESET       (ARESET),
    .buf_empty    (buf_empty),
    .buf_data     (buf_data),
    .buf_pop      (buf_pop),
    .M_AXIS_tdata (M_AXIS_tdata),
    .M_AXIS_tkeep (M_AXIS_tkeep),
    .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tlast (M_AXIS_tlast),
    .M_AXIS_tready(M_AXIS_tready),
    .frame_count  (frame_count),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  beat_t       exp_q[$];
  logic [63:0] src_q[$];
  int          mbeat, exp_frames, words_pushed, beats_pushed, popped, accepted;
  int          cyc, first_acc, last_acc;
  int          n_cmp, n_bad;
  bit          rst_on;
  int unsigned rdy_pct;
  bit          stall;
  logic [63:0] stall_d;
  logic        stall_l;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Model: a frame is FLEN beats, last beat flagged, header (if any) carries completed-frame count
  function automatic void push_beat(input logic [63:0] dv);
    beat_t b;
    b.d = dv;
    b.l = (mbeat == FLEN - 1);
    exp_q.push_back(b);
    beats_pushed++;
    if (b.l) begin
      mbeat = 0;
      exp_frames++;
    end else begin
      mbeat++;
    end
  endfunction

  function automatic void push_word(input logic [63:0] w);
`ifdef FRAME_HEADER_EN
    if (mbeat == 0) push_beat({16'hE7A0, 16'(exp_frames), 16'(FW), 16'h0000});
`endif
    push_beat(w);
    src_q.push_back(w);
    words_pushed++;
  endfunction

  function automatic void push_pad();
    while (mbeat != 0) push_beat(64'd0);
  endfunction

  // One clock: drive on the falling edge, sample just after, DUT updates on the rising edge
  task automatic step();
    beat_t e;
    @(negedge clk);
    ARESET        = rst_on;
    buf_empty     = (src_q.size() == 0);
    buf_data      = buf_empty ? '0 : src_q[0];
    M_AXIS_tready = rst_on ? 1'b0 : ($urandom_range(99) < rdy_pct);
    #1;
    cyc++;
    if (rst_on) begin
      check("pop_in_reset", 64'(buf_pop), 64'd0);
      stall = 1'b0;
    end else begin
      check("pop_when_empty", 64'(buf_pop & buf_empty), 64'd0);
      if (stall) begin
        check("stall_valid", 64'(M_AXIS_tvalid), 64'd1);
        check("stall_data", M_AXIS_tdata, stall_d);
        check("stall_last", 64'(M_AXIS_tlast), 64'(stall_l));
      end
      if (buf_pop) begin
        void'(src_q.pop_front());
        popped++;
      end
      if (M_AXIS_tvalid && M_AXIS_tready) begin
        accepted++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 'x;
        check("beat_data", M_AXIS_tdata, e.d);
        check("beat_last", 64'(M_AXIS_tlast), 64'(e.l));
      end
      stall   = M_AXIS_tvalid & !M_AXIS_tready;
      stall_d = M_AXIS_tdata;
      stall_l = M_AXIS_tlast;
    end
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check("drained", 64'(exp_q.size()), 64'd0);
    step();
    step();
    check("frame_count", 64'(frame_count), 64'(exp_frames));
    check("pop_total", 64'(popped), 64'(words_pushed));
    check("accept_total", 64'(accepted), 64'(beats_pushed));
  endtask

  initial begin
    int base;
    int n;
    n_cmp = 0; n_bad = 0; cyc = 0; first_acc = -1; last_acc = -1;
    mbeat = 0; exp_frames = 0; words_pushed = 0; beats_pushed = 0; popped = 0; accepted = 0;
    stall = 1'b0; stall_d = '0; stall_l = 1'b0;
    rst_on = 1'b1; rdy_pct = 100;
    ARESET = 1'b1; buf_empty = 1'b0; buf_data = '0; M_AXIS_tready = 1'b0;

    // Reset held with a non-empty buffer
    src_q.push_back(64'hDEAD_BEEF_0000_0001);
    src_q.push_back(64'hDEAD_BEEF_0000_0002);
    repeat (3) step();
    @(negedge clk); #1;
    check("rst_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    check("rst_pop", 64'(buf_pop), 64'd0);
    check("rst_fcount", 64'(frame_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tlast", 64'(M_AXIS_tlast), 64'd0);
    check("rst_tdata", M_AXIS_tdata, 64'd0);
    check("rst_tkeep", 64'(M_AXIS_tkeep), 64'hFF);
    src_q.delete();
    rst_on = 1'b0;

    // Two back-to-back frames of words 1..16 with tready held high
    rdy_pct = 100;
    first_acc = -1;
    for (int i = 1; i <= 16; i++) push_word(64'(i));
    drain(200);
`ifndef FRAME_HEADER_EN
    check("no_gaps", 64'(last_acc - first_acc + 1), 64'd16);
`endif

    // Three frames of random data with 50% tready
    rdy_pct = 50;
    for (int i = 0; i < 3 * int'(FW); i++) push_word({$urandom, $urandom});
    drain(2000);

    // Starved frame: three words then zero padding to full length
    rdy_pct = 100;
    for (int i = 0; i < 3; i++) push_word({$urandom, $urandom});
    push_pad();
    drain(500);

    // Reset mid-frame while a beat is valid
    for (int i = 0; i < 5; i++) push_word({$urandom, $urandom});
    base = accepted;
    n = 0;
    while (accepted - base < 4 && n < 100) begin
      step();
      n++;
    end
    check("accepted_before_reset", 64'(accepted - base), 64'd4);
    rst_on = 1'b1;
    step();
    rst_on = 1'b0;
    @(negedge clk); #1;
    check("midrst_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    check("midrst_tlast", 64'(M_AXIS_tlast), 64'd0);
    check("midrst_fcount", 64'(frame_count), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    src_q.delete();
    mbeat = 0; exp_frames = 0; words_pushed = 0; beats_pushed = 0; popped = 0; accepted = 0;

    // Fresh frame after reset, random tready
    rdy_pct = 70;
    for (int i = 0; i < int'(FW); i++) push_word({$urandom, $urandom});
    drain(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
